servo_bank_ctrl: RTL and testbench

Multi-channel lock/servo controller: takes decoded command bytes from the UART receiver, holds an open/closed state per channel, drives one glitch-free servo PWM per channel, and sounds a retriggerable buzzer chirp on any state change. Sits between the UART byte receiver and the servo/buzzer pins. Generalises the single-servo lock path to `NUM_CH` channels, adds command validation, and adds optional auto-relock.

---
 rtl/servo_bank_ctrl.sv | 158 +++++++++++++++
 tb/tb_servo_bank_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_bank_ctrl.sv
// Multi-channel servo/lock controller: UART command decode, per-channel PWM and buzzer chirp.
// Optional per-channel auto-relock timers are built when SERVO_AUTOLOCK_EN is defined.
module servo_bank_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int PWM_PERIOD   = 1_000_000,
  parameter int PULSE_CLOSED = 50_000,
  parameter int PULSE_OPEN   = 100_000,
  parameter int BUZZ_CYC     = 50_000_000,
  parameter int AUTOLOCK_CYC = 500_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [NUM_CH-1:0] servo_pwm,
  output logic [NUM_CH-1:0] pos_state,
  output logic              buzzer,
  output logic              cmd_err
);

  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int BW = (BUZZ_CYC > 1) ? $clog2(BUZZ_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] W_OPEN    = CW'(PULSE_OPEN);
  localparam logic [CW-1:0] W_CLOSED  = CW'(PULSE_CLOSED);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYC - 1);
  localparam logic [3:0]    CH_LIM    = 4'(NUM_CH);

  typedef enum logic {ST_IDLE = 1'b0, ST_ON = 1'b1} buzz_st_t;

  logic [NUM_CH-1:0] r_pos, w_pos_next, w_cmd_hit, w_cmd_val, w_expire;
  logic [NUM_CH-1:0] r_pwm;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_width [NUM_CH];
  logic [BW-1:0]     r_bcnt, w_bcnt_next;
  buzz_st_t          r_state, w_state_next;
  logic              r_buzzer, r_cmd_err;
  logic              w_is_set, w_is_clr_all, w_change;
  logic [2:0]        w_ch;

  // Decode the byte into per-channel hit/value; a close-all hits every channel
  always_comb begin
    w_ch         = rx_data[6:4];
    w_is_set     = rx_data[7] && (rx_data[3:1] == 3'b000) && ({1'b0, w_ch} < CH_LIM);
    w_is_clr_all = (rx_data == 8'h00);
    w_cmd_hit    = '0;
    w_cmd_val    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cmd_hit[i] = rx_valid && (w_is_clr_all || (w_is_set && (3'(i) == w_ch)));
      w_cmd_val[i] = w_is_set && rx_data[0];
    end
  end

`ifdef SERVO_AUTOLOCK_EN
  localparam int TW = (AUTOLOCK_CYC > 1) ? $clog2(AUTOLOCK_CYC) : 1;
  localparam logic [TW-1:0] TMR_EXP = TW'(AUTOLOCK_CYC - 2);
  logic [TW-1:0] r_tmr [NUM_CH];

  // Expiry fires on the edge where the timer would reach AUTOLOCK_CYC-1
  always_comb begin
    w_expire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_expire[i] = r_pos[i] && (r_tmr[i] == TMR_EXP);
    end
  end

  // Per-channel open timers; any command to the channel or a close restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_tmr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_pos_next[i] || w_cmd_hit[i]) r_tmr[i] <= '0;
        else                                 r_tmr[i] <= r_tmr[i] + 1'b1;
      end
    end
  end
`else
  assign w_expire = '0;
`endif

  // Commands override a same-cycle expiry
  always_comb begin
    w_pos_next = r_pos;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pos_next[i] = w_cmd_hit[i] ? w_cmd_val[i] : (r_pos[i] && !w_expire[i]);
    end
    w_change = |(w_pos_next ^ r_pos);
  end

  // Buzzer FSM next-state: any position change (re)starts the chirp
  always_comb begin
    w_state_next = r_state;
    w_bcnt_next  = r_bcnt;
    case (r_state)
      ST_IDLE: begin
        w_bcnt_next = '0;
        if (w_change) w_state_next = ST_ON;
        else          w_state_next = ST_IDLE;
      end
      ST_ON: begin
        if (w_change) begin
          w_state_next = ST_ON;
          w_bcnt_next  = '0;
        end else if (r_bcnt == BUZZ_LAST) begin
          w_state_next = ST_IDLE;
          w_bcnt_next  = '0;
        end else begin
          w_state_next = ST_ON;
          w_bcnt_next  = r_bcnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_bcnt_next  = '0;
      end
    endcase
  end

  // State, buzzer and command-error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos     <= '0;
      r_state   <= ST_IDLE;
      r_bcnt    <= '0;
      r_buzzer  <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_pos     <= w_pos_next;
      r_state   <= w_state_next;
      r_bcnt    <= w_bcnt_next;
      r_buzzer  <= (w_state_next == ST_ON);
      r_cmd_err <= rx_valid && !(w_is_set || w_is_clr_all);
    end
  end

  // Widths only reload on the wrap cycle so frames in progress are never altered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_pwm <= '0;
      for (int i = 0; i < NUM_CH; i++) r_width[i] <= W_CLOSED;
    end else begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        r_pwm[i] <= (r_cnt < r_width[i]);
        if (r_cnt == CNT_LAST) r_width[i] <= r_pos[i] ? W_OPEN : W_CLOSED;
        else                   r_width[i] <= r_width[i];
      end
    end
  end

  assign servo_pwm = r_pwm;
  assign pos_state = r_pos;
  assign buzzer    = r_buzzer;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_servo_bank_ctrl.sv
// Scoreboard bench for servo_bank_ctrl: a timestamp-based reference model predicts events,
// buzzer windows and PWM frames; a negedge monitor compares against the DUT.
module tb_servo_bank_ctrl;
  localparam int NCH = 4, P = 100, PC = 5, PO = 10, BZ = 20, AC = 300;

  logic clk = 1'b0;
  logic rst, rx_valid;
  logic [7:0] rx_data;
  logic [NCH-1:0] servo_pwm, pos_state;
  logic buzzer, cmd_err;

  servo_bank_ctrl #(
    .NUM_CH(NCH), .PWM_PERIOD(P), .PULSE_CLOSED(PC), .PULSE_OPEN(PO),
    .BUZZ_CYC(BZ), .AUTOLOCK_CYC(AC)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .servo_pwm(servo_pwm), .pos_state(pos_state), .buzzer(buzzer), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             err;
    logic [NCH-1:0] pos;
    int             cyc;
  } ev_t;

  ev_t exp_q[$];
  int tests = 0, fails = 0;
  int cyc = 0;
  logic [NCH-1:0] m_pos = '0;
  logic [NCH-1:0] hist [4096];
  logic [NCH-1:0] seen_pos = '0;
  int  m_last_chg = -1000;
  int  r_rel = 0;
  bit  have_r = 1'b0;
  bit  prev_rst = 1'b1;
`ifdef SERVO_AUTOLOCK_EN
  int  m_open_vis [NCH];
`endif

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Reference model: cycle c sees the effect of inputs driven in cycle c-1
  always @(posedge clk) begin : model
    logic [NCH-1:0] np;
    bit err;
    int ch;
    cyc++;
    if (rst) begin
      m_pos = '0;
      exp_q.delete();
      m_last_chg = -1000;
      have_r = 1'b0;
      prev_rst = 1'b1;
      if (cyc < 4096) hist[cyc] = '0;
    end else begin
      if (prev_rst) begin
        r_rel = cyc - 1;
        have_r = 1'b1;
      end
      prev_rst = 1'b0;
      np = m_pos;
      err = 1'b0;
`ifdef SERVO_AUTOLOCK_EN
      for (int i = 0; i < NCH; i++)
        if (m_pos[i] && cyc == m_open_vis[i] + AC - 1) np[i] = 1'b0;
`endif
      if (rx_valid) begin
        if (rx_data == 8'h00) begin
          np = '0;
        end else if (rx_data[7] && rx_data[3:1] == 3'b000 && int'(rx_data[6:4]) < NCH) begin
          ch = int'(rx_data[6:4]);
          np[ch] = rx_data[0];
`ifdef SERVO_AUTOLOCK_EN
          if (rx_data[0]) m_open_vis[ch] = cyc;
`endif
        end else begin
          err = 1'b1;
        end
      end
      if (np != m_pos) begin
        exp_q.push_back('{1'b0, np, cyc});
        m_last_chg = cyc;
      end
      if (err) exp_q.push_back('{1'b1, m_pos, cyc});
      m_pos = np;
      if (cyc < 4096) hist[cyc] = m_pos;
    end
  end

  // Monitor: compares every cycle, pops the scoreboard on cmd_err or a position change
  always @(negedge clk) begin : monitor
    logic [NCH-1:0] epwm;
    int ph, s, w;
    ev_t e;
    if (rst) begin
      check("rst_pos_state", pos_state, 0);
      check("rst_buzzer", buzzer, 0);
      check("rst_servo_pwm", servo_pwm, 0);
      check("rst_cmd_err", cmd_err, 0);
      seen_pos = '0;
    end else if (have_r) begin
      check("buzzer", buzzer, (cyc >= m_last_chg && cyc < m_last_chg + BZ) ? 1 : 0);
      ph = (cyc - 1 - r_rel) % P;
      s  = cyc - 1 - ph;
      epwm = '0;
      for (int i = 0; i < NCH; i++) begin
        w = (s == r_rel) ? PC : (hist[s-1][i] ? PO : PC);
        epwm[i] = (ph < w);
      end
      check("servo_pwm", servo_pwm, epwm);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("event_late", cyc, e.cyc);
      end
      if (cmd_err || pos_state !== seen_pos) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {cmd_err, pos_state}, {1'b0, seen_pos});
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("cmd_err", cmd_err, e.err);
          check("pos_state", pos_state, e.pos);
        end
        seen_pos = pos_state;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 3))
      0: b = 8'h00;
      1, 2: b = {1'b1, 3'($urandom_range(0, 4)), 3'b000, 1'($urandom_range(0, 1))};
      default: b = 8'($urandom);
    endcase
    return b;
  endfunction

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(200);
    // open channel 2 mid-frame
    idle(40);
    send(8'hA1);
    idle(150);
    // rejected bytes
    send(8'hC1);
    idle(5);
    send(8'h83);
    idle(30);
    // retrigger then close-all
    send(8'h81);
    idle(9);
    send(8'h00);
    idle(40);
    // reset seven cycles into a chirp
    send(8'h81);
    idle(7);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(150);
    // randomized commands, including back-to-back strobes
    for (int k = 0; k < 60; k++) begin
      send(rand_byte());
      idle($urandom_range(0, 3));
    end
    send(8'h00);
    idle(40);
    // autolock: re-open 200 cycles after the first open
    send(8'h91);
    idle(199);
    send(8'h91);
    idle(350);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
